jtframe_lfbuf_linebuf: RTL and testbench

Double-buffered line store that sits upstream of the line-frame-buffer SRAM controller. The game's object engine draws one scan line at a time into the "game" bank. On completion the banks swap and the SRAM controller reads the finished line through `fb_addr`/`fb_din`, writes it to external SRAM, and then clears it. The block sequences the drawn line number (`ln_v`), issues the per-line start strobe to the game, toggles the frame bit at each vertical sync, and stalls the game while the controller still owns the other bank.

---
 rtl/jtframe_lfbuf_linebuf_pkg.sv | 23 ++
 rtl/jtframe_dual_ram.sv | 38 +++
 rtl/jtframe_lfbuf_linebuf.sv | 173 +++++++++++++++++
 tb/tb_jtframe_lfbuf_linebuf.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_lfbuf_linebuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_lfbuf_linebuf_pkg                                            |
// | Shared types and default constants for the double-buffered line     |
// | store feeding the line-frame-buffer SRAM controller.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package jtframe_lfbuf_linebuf_pkg;

   // Sequencer states, explicitly 2 bits wide
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_WAIT = 2'd2
   } lb_state_t;

   // Last visible line drawn each frame (240-line display)
   localparam int C_DEF_VLAST = 239;
   // Pixel value left behind after the controller clears a line
   localparam int C_DEF_CLRV  = 0;

endpackage : jtframe_lfbuf_linebuf_pkg
`default_nettype wire

// File: rtl/jtframe_dual_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_dual_ram                                                     |
// | Dual-port RAM. Port A: synchronous read (read-before-write), write. |
// | Port B: asynchronous read, synchronous write.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jtframe_dual_ram #(
   parameter int DW = 16,
   parameter int AW = 10
)(
   input  logic          clk,
   // port A
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] data_a,
   input  logic          we_a,
   output logic [DW-1:0] q_a,
   // port B
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] data_b,
   input  logic          we_b,
   output logic [DW-1:0] q_b
);

   logic [DW-1:0] r_mem [0:(2**AW)-1];

   // Both write ports and the registered port-A read; a same-address
   // port-A write returns the previous contents
   always_ff @(posedge clk) begin
      if (we_a) r_mem[addr_a] <= data_a;
      if (we_b) r_mem[addr_b] <= data_b;
      q_a <= r_mem[addr_a];
   end

   assign q_b = r_mem[addr_b];

endmodule : jtframe_dual_ram
`default_nettype wire

// File: rtl/jtframe_lfbuf_linebuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_lfbuf_linebuf                                                |
// | Double-buffered scan-line store. The game draws into one bank while |
// | the SRAM controller drains and clears the other; this block swaps   |
// | the banks, sequences line numbers and stalls the game when the      |
// | controller has not yet released its bank.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jtframe_lfbuf_linebuf
   import jtframe_lfbuf_linebuf_pkg::*;
#(
   parameter int            HW    = 9,
   parameter int            VW    = 8,
   parameter int            DW    = 16,
   parameter logic [VW-1:0] VLAST = VW'(C_DEF_VLAST),
   parameter logic [DW-1:0] CLRV  = DW'(C_DEF_CLRV)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vs,
   // game side
   input  logic [HW-1:0] ln_addr,
   input  logic [DW-1:0] ln_data,
   input  logic          ln_we,
   input  logic          ln_done,
   output logic          ln_hs,
   output logic [VW-1:0] ln_v,
   output logic [DW-1:0] ln_pxl,
   // controller side
   input  logic [HW-1:0] fb_addr,
   output logic [DW-1:0] fb_din,
   input  logic          fb_clr,
   input  logic          fb_done,
   output logic          ctl_ln_done,
   output logic [VW-1:0] ctl_ln_v,
   // status
   output logic          frame,
   output logic [7:0]    ovr_cnt
);

   lb_state_t r_state, w_nxt_state;

   logic r_vs_l, r_done_l, r_clr_l;
   logic r_gbank, r_busy, r_fbdone_seen;
   logic w_vs_rise, w_done_rise, w_clr_fall;
   logic w_start, w_abort, w_handoff, w_last;

   assign w_vs_rise   = vs      & ~r_vs_l;
   assign w_done_rise = ln_done & ~r_done_l;
   assign w_clr_fall  = ~fb_clr & r_clr_l;
   assign w_last      = (ln_v == VLAST);

   // Edge-detect history; vs/ln_done start high so a level already
   // present when reset is released is not mistaken for an edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vs_l   <= 1'b1;
         r_done_l <= 1'b1;
         r_clr_l  <= 1'b0;
      end else begin
         r_vs_l   <= vs;
         r_done_l <= ln_done;
         r_clr_l  <= fb_clr;
      end
   end

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nxt_state;
   end

   // Sequencer next state and per-cycle actions; vs always takes priority
   // over a line completion so a late line is dropped, not handed off
   always_comb begin
      w_nxt_state = r_state;
      w_start     = 1'b0;
      w_abort     = 1'b0;
      w_handoff   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_vs_rise) begin
               w_start     = 1'b1;
               w_nxt_state = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (w_vs_rise) begin
               w_start     = 1'b1;
               w_abort     = 1'b1;
               w_nxt_state = ST_DRAW;
            end else if (w_done_rise) begin
               if (!r_busy) w_handoff   = 1'b1;
               else         w_nxt_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_vs_rise) begin
               w_start     = 1'b1;
               w_abort     = 1'b1;
               w_nxt_state = ST_DRAW;
            end else if (!r_busy) begin
               w_handoff = 1'b1;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
      if (w_handoff) w_nxt_state = w_last ? ST_IDLE : ST_DRAW;
   end

   // Line numbering, strobes, bank swap and frame/overrun bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ln_hs       <= 1'b0;
         ln_v        <= '0;
         ctl_ln_done <= 1'b0;
         ctl_ln_v    <= '0;
         frame       <= 1'b0;
         ovr_cnt     <= 8'd0;
         r_gbank     <= 1'b0;
      end else begin
         ln_hs       <= w_start | (w_handoff & ~w_last);
         ctl_ln_done <= w_handoff;
         if (w_start) begin
            frame <= ~frame;
            ln_v  <= '0;
         end else if (w_handoff && !w_last) begin
            ln_v <= ln_v + VW'(1);
         end
         if (w_handoff) begin
            r_gbank  <= ~r_gbank;
            ctl_ln_v <= ln_v;
         end
         if (w_abort && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      end
   end

   // Controller ownership of its bank: taken at handoff, released at the
   // end of the first clear pass that follows the SRAM write completing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy        <= 1'b0;
         r_fbdone_seen <= 1'b0;
      end else if (w_handoff) begin
         r_busy        <= 1'b1;
         r_fbdone_seen <= 1'b0;
      end else if (r_busy) begin
         if (fb_done) r_fbdone_seen <= 1'b1;
         if (w_clr_fall && r_fbdone_seen) begin
            r_busy        <= 1'b0;
            r_fbdone_seen <= 1'b0;
         end
      end
   end

   jtframe_dual_ram #(
      .DW ( DW   ),
      .AW ( HW+1 )
   ) u_ram (
      .clk    ( clk                 ),
      .addr_a ( {r_gbank, ln_addr}  ),
      .data_a ( ln_data             ),
      .we_a   ( ln_we               ),
      .q_a    ( ln_pxl              ),
      .addr_b ( {~r_gbank, fb_addr} ),
      .data_b ( CLRV                ),
      .we_b   ( fb_clr              ),
      .q_b    ( fb_din              )
   );

endmodule : jtframe_lfbuf_linebuf
`default_nettype wire

// File: tb/tb_jtframe_lfbuf_linebuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jtframe_lfbuf_linebuf                                             |
// | Directed self-checking bench for the double-buffered line store.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jtframe_lfbuf_linebuf;

   logic        clk = 1'b0;
   logic        rst_n, vs, ln_we, ln_done, fb_clr, fb_done;
   logic [8:0]  ln_addr, fb_addr;
   logic [15:0] ln_data;
   logic        ln_hs, ctl_ln_done, frame;
   logic [7:0]  ln_v, ctl_ln_v, ovr_cnt;
   logic [15:0] ln_pxl, fb_din;

   int vecs = 0;
   int errs = 0;

   string       tq[$];
   logic [31:0] eq[$];

   always #5 clk = ~clk;

   jtframe_lfbuf_linebuf dut (
      .clk         ( clk         ),
      .rst_n       ( rst_n       ),
      .vs          ( vs          ),
      .ln_addr     ( ln_addr     ),
      .ln_data     ( ln_data     ),
      .ln_we       ( ln_we       ),
      .ln_done     ( ln_done     ),
      .ln_hs       ( ln_hs       ),
      .ln_v        ( ln_v        ),
      .ln_pxl      ( ln_pxl      ),
      .fb_addr     ( fb_addr     ),
      .fb_din      ( fb_din      ),
      .fb_clr      ( fb_clr      ),
      .fb_done     ( fb_done     ),
      .ctl_ln_done ( ctl_ln_done ),
      .ctl_ln_v    ( ctl_ln_v    ),
      .frame       ( frame       ),
      .ovr_cnt     ( ovr_cnt     )
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] exp);
      tq.push_back(tag);
      eq.push_back(exp);
   endtask

   task automatic compare_pop(input logic [31:0] obs);
      string       tag;
      logic [31:0] exp;
      if (eq.size() == 0) begin
         vecs++;
         assert (eq.size() != 0) else begin
            errs++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
         end
      end else begin
         tag = tq.pop_front();
         exp = eq.pop_front();
         check(tag, obs, exp);
      end
   endtask

   // controller finishes SRAM write, then one clear pass ends
   task automatic release_busy();
      fb_done = 1'b1; tick();
      fb_done = 1'b0; fb_clr = 1'b1; tick();
      fb_clr  = 1'b0; tick();
   endtask

   task automatic handoff_line(input int v);
      release_busy();
      expect_val("ctl_ln_v", 32'(v));
      ln_done = 1'b1; tick();
      check("ctl_ln_done_pulse", 32'(ctl_ln_done), 32'd1);
      compare_pop(32'(ctl_ln_v));
      ln_done = 1'b0; tick();
   endtask

   task automatic check_reset_outputs();
      check("rst_ln_hs",       32'(ln_hs),       32'd0);
      check("rst_ln_v",        32'(ln_v),        32'd0);
      check("rst_ctl_ln_done", 32'(ctl_ln_done), 32'd0);
      check("rst_ctl_ln_v",    32'(ctl_ln_v),    32'd0);
      check("rst_frame",       32'(frame),       32'd0);
      check("rst_ovr_cnt",     32'(ovr_cnt),     32'd0);
   endtask

   initial begin
      rst_n = 1'b0; vs = 1'b0; ln_we = 1'b0; ln_done = 1'b0;
      fb_clr = 1'b0; fb_done = 1'b0; ln_addr = '0; fb_addr = '0; ln_data = '0;
      tick(); tick();
      check_reset_outputs();
      rst_n = 1'b1; tick();

      // frame start
      vs = 1'b1; tick();
      check("start_ln_hs", 32'(ln_hs), 32'd1);
      check("start_ln_v",  32'(ln_v),  32'd0);
      check("start_frame", 32'(frame), 32'd1);
      vs = 1'b0; tick();
      check("start_ln_hs_drop", 32'(ln_hs), 32'd0);

      // draw line 0 and hand it off
      ln_addr = 9'd5; ln_data = 16'h1234; ln_we = 1'b1; tick();
      ln_we = 1'b0; fb_addr = 9'd5;
      expect_val("ctl_ln_v_first", 32'd0);
      ln_done = 1'b1; tick();
      check("first_ctl_ln_done", 32'(ctl_ln_done), 32'd1);
      compare_pop(32'(ctl_ln_v));
      check("first_fb_din", 32'(fb_din), 32'h1234);
      check("first_ln_hs",  32'(ln_hs),  32'd1);
      check("first_ln_v",   32'(ln_v),   32'd1);
      ln_done = 1'b0; tick();
      check("first_ctl_drop", 32'(ctl_ln_done), 32'd0);

      // line 1 completes while the controller still owns its bank
      ln_addr = 9'd7; ln_data = 16'hBEEF; ln_we = 1'b1; tick();
      ln_we = 1'b0;
      ln_done = 1'b1; tick();
      check("busy_no_ctl", 32'(ctl_ln_done), 32'd0);
      check("busy_no_hs",  32'(ln_hs),       32'd0);
      ln_done = 1'b0; tick(); tick();
      fb_done = 1'b1; tick();
      fb_done = 1'b0; fb_clr = 1'b1; tick();
      check("clear_visible", 32'(fb_din), 32'd0);
      fb_clr = 1'b0; tick();
      check("wait_no_ctl_yet", 32'(ctl_ln_done), 32'd0);
      expect_val("ctl_ln_v_wait", 32'd1);
      tick();
      check("wait_ctl_ln_done", 32'(ctl_ln_done), 32'd1);
      compare_pop(32'(ctl_ln_v));
      check("wait_ln_v", 32'(ln_v),  32'd2);
      check("wait_hs",   32'(ln_hs), 32'd1);
      fb_addr = 9'd7; #1;
      check("wait_fb_din", 32'(fb_din), 32'hBEEF);

      // full clear sweep while the game fills its own bank
      fb_clr = 1'b1; ln_we = 1'b1;
      for (int i = 0; i < 512; i++) begin
         fb_addr = 9'(i); ln_addr = 9'(i); ln_data = 16'(i) ^ 16'hA5A5;
         tick();
      end
      fb_clr = 1'b0; ln_we = 1'b0; tick();
      for (int i = 0; i < 512; i += 37) begin
         fb_addr = 9'(i); tick();
         check("clr_sweep", 32'(fb_din), 32'd0);
      end
      fb_addr = 9'd511; tick();
      check("clr_sweep_last", 32'(fb_din), 32'd0);
      for (int i = 0; i < 512; i += 41) begin
         ln_addr = 9'(i); tick();
         check("game_intact", 32'(ln_pxl), 32'(16'(i) ^ 16'hA5A5));
      end
      ln_addr = 9'd9; ln_data = 16'h7777; ln_we = 1'b1; tick();
      check("rdw_old", 32'(ln_pxl), 32'(16'd9 ^ 16'hA5A5));
      ln_we = 1'b0; tick();
      check("rdw_new", 32'(ln_pxl), 32'h7777);

      // run to the last line
      for (int v = 2; v < 239; v++) handoff_line(v);
      check("pre_last_ln_v", 32'(ln_v), 32'd239);
      release_busy();
      expect_val("ctl_ln_v_last", 32'd239);
      ln_done = 1'b1; tick();
      check("last_ctl_ln_done", 32'(ctl_ln_done), 32'd1);
      compare_pop(32'(ctl_ln_v));
      check("last_no_hs", 32'(ln_hs), 32'd0);
      check("last_ln_v",  32'(ln_v),  32'd239);
      ln_done = 1'b0; tick();
      release_busy();
      ln_done = 1'b1; tick();
      check("idle_ignores_done", 32'(ctl_ln_done), 32'd0);
      check("idle_no_hs",        32'(ln_hs),       32'd0);
      ln_done = 1'b0; tick();
      vs = 1'b1; tick();
      check("frame2_frame", 32'(frame), 32'd0);
      check("frame2_ln_v",  32'(ln_v),  32'd0);
      check("frame2_hs",    32'(ln_hs), 32'd1);
      vs = 1'b0; tick();

      // abort at line 100 with coincident ln_done
      for (int v = 0; v < 100; v++) handoff_line(v);
      check("abort_pre_ln_v", 32'(ln_v), 32'd100);
      release_busy();
      vs = 1'b1; ln_done = 1'b1; tick();
      check("abort_no_ctl", 32'(ctl_ln_done), 32'd0);
      check("abort_ovr",    32'(ovr_cnt),     32'd1);
      check("abort_ln_v",   32'(ln_v),        32'd0);
      check("abort_hs",     32'(ln_hs),       32'd1);
      check("abort_frame",  32'(frame),       32'd1);
      vs = 1'b0; ln_done = 1'b0; tick();
      for (int k = 0; k < 300; k++) begin
         vs = 1'b1; tick();
         vs = 1'b0; tick();
      end
      check("ovr_saturate", 32'(ovr_cnt), 32'd255);
      check("ovr_frame",    32'(frame),   32'd1);

      // reset while stalled in WAIT, vs held high across release
      ln_done = 1'b1; tick();
      check("pre_rst_handoff", 32'(ctl_ln_done), 32'd1);
      ln_done = 1'b0; tick();
      ln_done = 1'b1; tick();
      check("pre_rst_wait", 32'(ctl_ln_done), 32'd0);
      ln_done = 1'b0; vs = 1'b1; rst_n = 1'b0; tick();
      check_reset_outputs();
      rst_n = 1'b1; tick(); tick();
      check("rel_no_hs",    32'(ln_hs), 32'd0);
      check("rel_no_frame", 32'(frame), 32'd0);
      vs = 1'b0; tick();
      vs = 1'b1; tick();
      check("rel_new_hs",    32'(ln_hs), 32'd1);
      check("rel_new_frame", 32'(frame), 32'd1);
      vs = 1'b0; tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule : tb_jtframe_lfbuf_linebuf
`default_nettype wire
